// File: rtl/ul_il_rep_sched.sv
// NB-IoT uplink interleaver repetition scheduler: takes one 16-bit block and replays it n_rep times.
// Optional stall watchdog on il_done is built when IL_SCHED_WATCHDOG_EN is defined.
module ul_il_rep_sched #(
    parameter int unsigned TOTAL_BITS = 24,
    parameter int unsigned REP_W      = 8,
    parameter int unsigned CNT_W      = 6,
    parameter int unsigned WD_LIMIT   = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [REP_W-1:0] n_rep_i,
    input  logic             blk_valid_i,
    input  logic [15:0]      blk_data_i,
    output logic             blk_ready_o,
    input  logic             dn_ready_i,
    output logic             il_reset_o,
    output logic             il_en_o,
    output logic [15:0]      il_data_o,
    input  logic             il_bit_i,
    input  logic             il_done_i,
    output logic             out_valid_o,
    output logic             out_bit_o,
    output logic             out_last_o,
    output logic [REP_W-1:0] rep_idx_o,
    output logic             busy_o,
    output logic             err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitBlk,
        StClr,
        StWaitDn,
        StRun,
        StNext
    } state_e;

    localparam logic [CNT_W-1:0] RdEnd    = CNT_W'(2 * TOTAL_BITS);
    localparam logic [CNT_W-1:0] OutFirst = CNT_W'(TOTAL_BITS + 1);

    state_e           state_q;
    logic [REP_W-1:0] reps_q;
    logic [REP_W-1:0] rep_idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [15:0]      il_data_q;
    logic             blk_ready_q;
    logic             il_reset_q;
    logic             il_en_q;
    logic             out_valid_q;
    logic             out_bit_q;
    logic             out_last_q;
    logic             busy_q;

    logic in_win;
    logic last_rep;
    logic done_ok;
    logic wd_trip;

    assign cnt_d    = cnt_q + CNT_W'(1);
    // Interleaver output is valid one cycle after each read-phase enable.
    assign in_win   = (state_q == StRun) && (cnt_q >= OutFirst) && (cnt_q <= RdEnd);
    assign last_rep = (rep_idx_q == reps_q - REP_W'(1));

`ifdef IL_SCHED_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WdEnd = CNT_W'(2 * TOTAL_BITS + WD_LIMIT);

    logic err_q;

    assign done_ok = il_done_i;
    assign wd_trip = (cnt_q == WdEnd) && !il_done_i;
    assign err_o   = err_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else if ((state_q == StRun) && wd_trip) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_wd;

    assign unused_wd = il_done_i ^ (WD_LIMIT != 0);
    assign done_ok   = 1'b1;
    assign wd_trip   = 1'b0;
    assign err_o     = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            reps_q      <= '0;
            rep_idx_q   <= '0;
            cnt_q       <= '0;
            il_data_q   <= '0;
            blk_ready_q <= 1'b0;
            il_reset_q  <= 1'b1;
            il_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            il_reset_q  <= 1'b0;
            il_en_q     <= 1'b0;
            out_valid_q <= in_win;
            out_bit_q   <= in_win & il_bit_i;
            out_last_q  <= in_win && (cnt_q == RdEnd) && done_ok && last_rep;

            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        reps_q      <= (n_rep_i == '0) ? REP_W'(1) : n_rep_i;
                        rep_idx_q   <= '0;
                        busy_q      <= 1'b1;
                        blk_ready_q <= 1'b1;
                        state_q     <= StWaitBlk;
                    end
                end
                StWaitBlk: begin
                    if (blk_valid_i) begin
                        il_data_q   <= blk_data_i;
                        blk_ready_q <= 1'b0;
                        il_reset_q  <= 1'b1;
                        state_q     <= StClr;
                    end
                end
                StClr: begin
                    cnt_q   <= '0;
                    state_q <= StWaitDn;
                end
                StWaitDn: begin
                    if (dn_ready_i) begin
                        il_en_q <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    cnt_q   <= cnt_d;
                    il_en_q <= (cnt_d < RdEnd);
                    // The counter, not an early il_done, decides when a repetition ends.
                    if ((cnt_q >= RdEnd) && done_ok) begin
                        state_q <= StNext;
                    end else if (wd_trip) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StNext: begin
                    if (last_rep) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        rep_idx_q  <= rep_idx_q + REP_W'(1);
                        il_reset_q <= 1'b1;
                        state_q    <= StClr;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Reset reaches the interleaver in the same cycle it is applied here.
    assign il_reset_o  = il_reset_q | reset_i;
    assign il_en_o     = il_en_q;
    assign il_data_o   = il_data_q;
    assign blk_ready_o = blk_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_bit_o   = out_bit_q;
    assign out_last_o  = out_last_q;
    assign rep_idx_o   = rep_idx_q;
    assign busy_o      = busy_q;

endmodule
